// File: rtl/dram_req_master.sv
// Requester for the dREN/dWEN/ram_wait DRAM interface: arbitrates a fetch port and a
// read/write data port, one outstanding transaction, with a sticky stall watchdog.
module dram_req_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              c0_req,
    input  logic [ADDR_W-1:0] c0_addr,
    output logic [DATA_W-1:0] c0_rdata,
    output logic              c0_ack,
    input  logic              c1_req,
    input  logic              c1_wen,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              c1_ack,
    output logic              dREN,
    output logic              dWEN,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_wait,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             last_grant;
    logic             gnt;
    logic             is_wr;
    logic             nxt_gnt;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        nxt_gnt = c1_req;
        if (c0_req && c1_req)
            nxt_gnt = ~last_grant;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            dREN        <= 1'b0;
            dWEN        <= 1'b0;
            ram_addr    <= '0;
            ram_store   <= '0;
            c0_ack      <= 1'b0;
            c1_ack      <= 1'b0;
            c0_rdata    <= '0;
            c1_rdata    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
            last_grant  <= 1'b1;
            gnt         <= 1'b0;
            is_wr       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (c0_req || c1_req) begin
                        gnt        <= nxt_gnt;
                        last_grant <= nxt_gnt;
                        is_wr      <= nxt_gnt & c1_wen;
                        dWEN       <= nxt_gnt & c1_wen;
                        dREN       <= ~(nxt_gnt & c1_wen);
                        ram_addr   <= nxt_gnt ? c1_addr : c0_addr;
                        if (nxt_gnt)
                            ram_store <= c1_wdata;
                        wait_cnt   <= '0;
                        busy       <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (!ram_wait) begin
                        dREN <= 1'b0;
                        dWEN <= 1'b0;
                        if (!is_wr) begin
                            if (gnt)
                                c1_rdata <= ram_load;
                            else
                                c0_rdata <= ram_load;
                        end
                        if (gnt)
                            c1_ack <= 1'b1;
                        else
                            c0_ack <= 1'b1;
                        state <= ACK;
                    end else begin
                        if (wait_cnt != '1)
                            wait_cnt <= wait_cnt + 1'b1;
                        // Watchdog only flags; the request stays on the bus.
                        if (TIMEOUT != 0 && wait_cnt == CNT_W'(TIMEOUT - 1))
                            timeout_err <= 1'b1;
                    end
                end
                ACK: begin
                    c0_ack <= 1'b0;
                    c1_ack <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_req_master.sv
// Bench for dram_req_master: vector table of single transactions with an ack scoreboard,
// plus hand sequences for alternating arbitration and reset mid-transaction.
module tb_dram_req_master;

    localparam int unsigned TO = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic        c0_req, c1_req, c1_wen, ram_wait;
    logic [31:0] c0_addr, c1_addr, c1_wdata, ram_load;
    logic [31:0] c0_rdata, c1_rdata, ram_addr, ram_store;
    logic        c0_ack, c1_ack, dREN, dWEN, busy, timeout_err;

    dram_req_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .c0_req(c0_req), .c0_addr(c0_addr), .c0_rdata(c0_rdata), .c0_ack(c0_ack),
        .c1_req(c1_req), .c1_wen(c1_wen), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_rdata(c1_rdata), .c1_ack(c1_ack),
        .dREN(dREN), .dWEN(dWEN), .ram_addr(ram_addr), .ram_store(ram_store),
        .ram_load(ram_load), .ram_wait(ram_wait), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          port;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] load;
        int unsigned wait_n;
        bit          drop;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
    } sb_t;

    vec_t vecs[8];
    sb_t  sb[$];
    int   checks = 0;
    int   passes = 0;
    int   dual_strobe = 0;
    bit   to_model = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge CLK) begin
        if (dREN && dWEN) dual_strobe++;
        if (c0_ack && c1_ack) begin
            chk("dual_ack", {c1_ack, c0_ack}, 2'b01);
        end else if (c0_ack || c1_ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {c1_ack, c0_ack}, 2'b00);
            end else begin
                sb_t it;
                it = sb.pop_front();
                chk("ack_port", c1_ack, it.port);
                chk("ack_rdata", c1_ack ? c1_rdata : c0_rdata, it.rdata);
            end
        end
    end

    task automatic do_reset();
        RST = 1'b1;
        c0_req = 0; c1_req = 0; c1_wen = 0; ram_wait = 0;
        c0_addr = '0; c1_addr = '0; c1_wdata = '0; ram_load = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        to_model = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        sb.push_back('{port: v.port, rdata: v.exp_rdata});
        if (v.port) begin
            c1_req = 1; c1_wen = v.wen; c1_addr = v.addr; c1_wdata = v.wdata;
        end else begin
            c0_req = 1; c0_addr = v.addr;
        end
        ram_wait = (v.wait_n != 0);
        ram_load = v.load;
        @(posedge CLK); @(negedge CLK);
        chk("grant_dREN", dREN, !v.wen);
        chk("grant_dWEN", dWEN, v.wen);
        chk("grant_addr", ram_addr, v.addr);
        chk("grant_busy", busy, 1'b1);
        if (v.wen) chk("grant_store", ram_store, v.wdata);
        if (v.drop) begin
            c1_req = 0; c1_addr = '0; c0_req = 0; c0_addr = '0;
        end
        for (int unsigned k = 1; k <= v.wait_n; k++) begin
            @(posedge CLK); @(negedge CLK);
            if (k >= TO) to_model = 1'b1;
            chk("wait_strobe", {dWEN, dREN}, v.wen ? 2'b10 : 2'b01);
            chk("wait_addr", ram_addr, v.addr);
            chk("wait_timeout", timeout_err, to_model);
            if (k == v.wait_n) ram_wait = 1'b0;
        end
        @(posedge CLK); @(negedge CLK);
        chk("done_strobe", {dWEN, dREN}, 2'b00);
        chk("done_ack", {c1_ack, c0_ack}, v.port ? 2'b10 : 2'b01);
        chk("done_timeout", timeout_err, to_model);
        c0_req = 0; c1_req = 0;
        @(posedge CLK); @(negedge CLK);
        chk("ack_one_cycle", {c1_ack, c0_ack}, 2'b00);
        chk("idle_busy", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        //        port wen addr          wdata         load          wait drop exp_rdata
        vecs[0] = '{0, 0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 4,  0, 32'hDEAD_BEEF};
        vecs[1] = '{1, 1, 32'h0000_2000, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0, 32'h0};
        vecs[2] = '{1, 0, 32'h0000_2004, 32'h0,        32'hCAFE_F00D, 2,  0, 32'hCAFE_F00D};
        vecs[3] = '{1, 1, 32'h0000_2008, 32'h8765_4321, 32'h1111_1111, 1, 0, 32'hCAFE_F00D};
        vecs[4] = '{0, 0, 32'hFFFF_FFFC, 32'h0,        32'h0BAD_F00D, 7,  0, 32'h0BAD_F00D};
        vecs[5] = '{1, 0, 32'h0000_3000, 32'h0,        32'h1357_9BDF, 3,  1, 32'h1357_9BDF};
        vecs[6] = '{0, 0, 32'h0000_0400, 32'h0,        32'hA5A5_A5A5, 20, 0, 32'hA5A5_A5A5};
        vecs[7] = '{1, 1, 32'h0000_0500, 32'h5555_AAAA, 32'h2222_2222, 0, 0, 32'h1357_9BDF};

        do_reset();
        chk("rst_strobes", {dREN, dWEN}, 2'b00);
        chk("rst_addr", ram_addr, 32'h0);
        chk("rst_store", ram_store, 32'h0);
        chk("rst_acks", {c0_ack, c1_ack}, 2'b00);
        chk("rst_rdata", {c0_rdata, c1_rdata}, 64'h0);
        chk("rst_busy_to", {busy, timeout_err}, 2'b00);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Both ports requesting continuously: grants alternate starting with port 0.
        do_reset();
        c0_req = 1; c0_addr = 32'h10;
        c1_req = 1; c1_wen = 0; c1_addr = 32'h20;
        ram_wait = 0;
        for (int i = 0; i < 4; i++) begin
            ram_load = 32'h1000 + i;
            sb.push_back('{port: i[0], rdata: 32'h1000 + i});
            @(posedge CLK); @(negedge CLK);
            chk("arb_addr", ram_addr, i[0] ? 32'h20 : 32'h10);
            chk("arb_strobe", {dWEN, dREN}, 2'b01);
            repeat (2) @(posedge CLK);
            @(negedge CLK);
        end
        c0_req = 0; c1_req = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("arb_idle", busy, 1'b0);

        // Reset while a read is stalled: no ack, outputs cleared, then a clean retry.
        c0_req = 1; c0_addr = 32'h0000_0700; ram_wait = 1;
        @(posedge CLK); @(negedge CLK);
        chk("pre_rst_dREN", dREN, 1'b1);
        RST = 1; c0_req = 0;
        @(posedge CLK); @(negedge CLK);
        chk("mid_rst_dREN", dREN, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ack", {c0_ack, c1_ack}, 2'b00);
        chk("mid_rst_addr", ram_addr, 32'h0);
        RST = 0; to_model = 1'b0;
        @(posedge CLK); @(negedge CLK);
        chk("post_rst_ack", {c0_ack, c1_ack}, 2'b00);
        run_vec('{0, 0, 32'h0000_0700, 32'h0, 32'h7777_0001, 2, 0, 32'h7777_0001});

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("sb_drained", sb.size(), 0);
        chk("no_dual_strobe", dual_strobe, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
